// File: rtl/key_event_encoder.sv
// Key gesture classifier: turns debounced press/release pulses into one ASCII
// code per gesture (short press, long press, double click) and queues the codes
// in a 4-entry first-word-fall-through FIFO with a valid/ready output.
module key_event_encoder #(
    parameter int unsigned LONG_CYC = 50_000_000,
    parameter int unsigned DCLK_CYC = 15_000_000,
    parameter logic [7:0]  CODE_S   = 8'h53,
    parameter logic [7:0]  CODE_L   = 8'h4C,
    parameter logic [7:0]  CODE_D   = 8'h44
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key_pulse,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       ovf,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StPress1 = 3'd1,
        StHeld   = 3'd2,
        StWait2  = 3'd3,
        StPress2 = 3'd4
    } state_e;

    localparam logic [31:0] LongLast = 32'(LONG_CYC - 1);
    localparam logic [31:0] DclkLast = 32'(DCLK_CYC - 1);

    state_e      state_q, state_d;
    logic [31:0] cnt_q;
    logic        mask_q;
    logic        key_evt;
    logic        push;
    logic [7:0]  push_code;

    logic [7:0]  mem_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q;
    logic        ovf_q;
    logic        full, pop, wr_en;

    // The debouncer emits a spurious pulse out of reset; drop the first edge's pulse.
    assign key_evt = key_pulse & ~mask_q;

    // Reset-release mask: high only until the first clock edge after reset.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) mask_q <= 1'b1;
        else         mask_q <= 1'b0;
    end

    // Gesture decision: next state plus the code to emit on this edge, if any.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_code = CODE_S;
        case (state_q)
            StIdle: begin
                if (key_evt) state_d = StPress1;
            end
            StPress1: begin
                // A release on the long-press boundary still counts as a short press.
                if (key_evt) begin
                    state_d = StWait2;
                end else if (cnt_q == LongLast) begin
                    state_d   = StHeld;
                    push      = 1'b1;
                    push_code = CODE_L;
                end
            end
            StHeld: begin
                if (key_evt) state_d = StIdle;
            end
            StWait2: begin
                // A second press on the timeout edge still makes a double click.
                if (key_evt) begin
                    state_d = StPress2;
                end else if (cnt_q == DclkLast) begin
                    state_d   = StIdle;
                    push      = 1'b1;
                    push_code = CODE_S;
                end
            end
            StPress2: begin
                if (key_evt) begin
                    state_d   = StIdle;
                    push      = 1'b1;
                    push_code = CODE_D;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register and gesture timer; the timer restarts on every transition.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q == StPress1 || state_q == StWait2) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign full  = (count_q == 3'd4);
    assign pop   = (count_q != 3'd0) && tx_ready;
    // A push into a full FIFO still lands if the head leaves on the same edge.
    assign wr_en = push && (!full || pop);

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + 3'(wr_en) - 3'(pop);
            if (push && full && !pop) ovf_q <= 1'b1;
        end
    end

    // FIFO storage; cleared on reset so tx_data reads 0 until the first push.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= push_code;
        end
    end

    assign tx_data   = mem_q[rd_ptr_q];
    assign tx_valid  = (count_q != 3'd0);
    assign ovf       = ovf_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder with shortened timing (LONG_CYC=100, DCLK_CYC=40).
module tb_key_event_encoder;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       key_pulse = 1'b0;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       ovf;
    logic [2:0] fsm_state;

    int total = 0;
    int bad   = 0;

    key_event_encoder #(
        .LONG_CYC(100),
        .DCLK_CYC(40),
        .CODE_S  (8'h53),
        .CODE_L  (8'h4C),
        .CODE_D  (8'h44)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .key_pulse(key_pulse),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .ovf      (ovf),
        .fsm_state(fsm_state)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n edges; afterwards sit 1 time unit past the last edge.
    task automatic cycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // One-cycle key pulse consumed by the next edge.
    task automatic pulse();
        key_pulse = 1'b1;
        cycles(1);
        key_pulse = 1'b0;
    endtask

    task automatic pop_one();
        tx_ready = 1'b1;
        cycles(1);
        tx_ready = 1'b0;
    endtask

    // Press, release 5 edges later, then let the double-click window expire.
    task automatic short_press();
        pulse();
        cycles(4);
        pulse();
        cycles(40);
    endtask

    task automatic do_reset();
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        #3;
        sys_rst = 1'b0;
        cycles(1);
    endtask

    initial begin
        // 1. reset state and masked first pulse
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_data", 32'(tx_data), 32'h00);
        chk("rst_ovf", 32'(ovf), 32'd0);
        sys_rst   = 1'b0;
        key_pulse = 1'b1;
        cycles(1);
        key_pulse = 1'b0;
        chk("mask_state", 32'(fsm_state), 32'd0);
        chk("mask_valid", 32'(tx_valid), 32'd0);

        // 2. short press
        pulse();
        chk("s_press_state", 32'(fsm_state), 32'd1);
        cycles(19);
        pulse();
        chk("s_wait2_state", 32'(fsm_state), 32'd3);
        cycles(39);
        chk("s_before_valid", 32'(tx_valid), 32'd0);
        cycles(1);
        chk("s_valid", 32'(tx_valid), 32'd1);
        chk("s_data", 32'(tx_data), 32'h53);
        chk("s_idle", 32'(fsm_state), 32'd0);
        pop_one();
        chk("s_popped", 32'(tx_valid), 32'd0);

        // 3. long press
        pulse();
        cycles(99);
        chk("l_before_valid", 32'(tx_valid), 32'd0);
        chk("l_before_state", 32'(fsm_state), 32'd1);
        cycles(1);
        chk("l_valid", 32'(tx_valid), 32'd1);
        chk("l_data", 32'(tx_data), 32'h4C);
        chk("l_held", 32'(fsm_state), 32'd2);
        cycles(49);
        pulse();
        chk("l_idle", 32'(fsm_state), 32'd0);
        pop_one();
        chk("l_single", 32'(tx_valid), 32'd0);
        cycles(50);
        chk("l_no_second", 32'(tx_valid), 32'd0);

        // 4a. double click with a long second hold
        pulse();
        cycles(9);
        pulse();
        cycles(14);
        pulse();
        chk("d_press2", 32'(fsm_state), 32'd4);
        cycles(199);
        chk("d_no_early", 32'(tx_valid), 32'd0);
        pulse();
        chk("d_valid", 32'(tx_valid), 32'd1);
        chk("d_data", 32'(tx_data), 32'h44);
        chk("d_idle", 32'(fsm_state), 32'd0);
        pop_one();
        chk("d_single", 32'(tx_valid), 32'd0);

        // 4b. second press lands on the window's last count
        pulse();
        cycles(9);
        pulse();
        cycles(39);
        pulse();
        chk("db_press2", 32'(fsm_state), 32'd4);
        chk("db_no_s", 32'(tx_valid), 32'd0);
        pulse();
        chk("db_data", 32'(tx_data), 32'h44);
        pop_one();
        chk("db_single", 32'(tx_valid), 32'd0);

        // 5a. overflow with a stalled consumer
        for (int i = 0; i < 4; i++) short_press();
        chk("o_ovf_4", 32'(ovf), 32'd0);
        short_press();
        chk("o_ovf_5", 32'(ovf), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("o_valid", 32'(tx_valid), 32'd1);
            chk("o_data", 32'(tx_data), 32'h53);
            pop_one();
        end
        chk("o_empty", 32'(tx_valid), 32'd0);
        chk("o_ovf_sticky", 32'(ovf), 32'd1);

        // 5b. push into a full FIFO alongside a pop
        do_reset();
        chk("r_ovf_clear", 32'(ovf), 32'd0);
        for (int i = 0; i < 4; i++) short_press();
        pulse();
        cycles(4);
        pulse();
        cycles(39);
        tx_ready = 1'b1;
        cycles(1);
        tx_ready = 1'b0;
        chk("p_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("p_valid", 32'(tx_valid), 32'd1);
            pop_one();
        end
        chk("p_empty", 32'(tx_valid), 32'd0);

        // 6. asynchronous reset mid-press with bytes queued
        short_press();
        short_press();
        pulse();
        cycles(5);
        chk("a_pre_state", 32'(fsm_state), 32'd1);
        chk("a_pre_valid", 32'(tx_valid), 32'd1);
        #1;
        sys_rst = 1'b1;
        #1;
        chk("a_valid", 32'(tx_valid), 32'd0);
        chk("a_state", 32'(fsm_state), 32'd0);
        chk("a_ovf", 32'(ovf), 32'd0);
        chk("a_data", 32'(tx_data), 32'h00);
        #1;
        sys_rst = 1'b0;
        cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
